audio_frame_scheduler: RTL
==========================

Name: audio_frame_scheduler

Overview:
- Shares the codec's stereo playback path between two stereo frame requesters: src0 (sound effects) and src1 (music/tone).
- Arbitrates between them and buffers accepted frames in a small FIFO.
- Drives the codec core's separate left and right Avalon-ST sinks, popping a frame only after both channels have accepted it.
- Sits between the sample producers and the audio core inside the audio subsystem; all logic is on the system clock.

Parameters:
DATA_W, 16, sample width in bits, signed two's complement
FIFO_DEPTH, 4, frame FIFO entries; must be a power of two, at least 2
ADDR_W, 2, log2(FIFO_DEPTH)

Ports:
clk_clk  in  1  system clock; all logic on rising edge
reset_reset_n  in  1  synchronous active-low reset
enable  in  1  1 = run; 0 = stall both sides, contents kept
flush  in  1  1-cycle pulse; empties FIFO
src0_left, src0_right  in  DATA_W each  requester 0 frame
src0_valid  in  1  requester 0 frame valid
src0_ready  out  1  requester 0 frame accepted this cycle when valid
src1_left, src1_right, src1_valid, src1_ready  same for requester 1
left_data  out  DATA_W  to audio core left channel sink data
left_valid  out  1  left channel sink valid
left_ready  in  1  left channel sink ready
right_data, right_valid, right_ready  same for right channel sink
fifo_level  out  ADDR_W+1  frames currently stored, 0..FIFO_DEPTH
underrun_count  out  8  saturating count of starved cycles

Behaviour:
- Reset (reset_reset_n=0 at edge):
  - Write/read pointers 0, fifo_level 0, left_done and right_done 0.
  - last_grant=1, so src0 wins the first contest.
  - underrun_count 0.
  - All valid/ready outputs 0; left_data and right_data 0.
  - Reset mid-transfer discards a half-sent frame.
- Input arbitration (combinational):
  - full = (level == FIFO_DEPTH).
  - srcN_ready = enable & ~flush & ~full & grantN.
  - Only one source valid: that source is granted.
  - Both valid: the source other than last_grant is granted (round robin).
  - last_grant updates only on an accepted handshake.
- Push: on srcN_valid & srcN_ready, {left,right} is written at wr_ptr on the edge, wr_ptr increments (wraps mod FIFO_DEPTH), level increments.
  - The frame is visible at the sink outputs the cycle after acceptance.
  - No push while full, even if a pop occurs that cycle.
- Output: head = mem[rd_ptr].
  - left_valid = enable & (level != 0) & ~left_done.
  - right_valid = enable & (level != 0) & ~right_done.
  - Data outputs are the head samples when the matching valid is 1, else 0.
- Per-channel completion:
  - Left handshake with right not yet complete (not done and not handshaking): set left_done. Right is symmetric.
  - Pop when both channels are complete: both handshake in the same cycle, or one handshakes while the other's done flag is already set.
  - On pop: rd_ptr increments (wraps), level decrements, both done flags clear.
- Simultaneous push and pop: level unchanged, both pointers advance.
- enable=0: all readys and valids 0; pointers, level, done flags and memory hold; no underrun counting.
- flush=1 (takes priority over push and pop; reset takes priority over flush):
  - Pointers 0, level 0, done flags 0, readys forced 0 that cycle.
  - last_grant and underrun_count unchanged.
- Underrun: each cycle with enable=1, level==0 and (left_ready | right_ready), underrun_count increments; saturates at 255.
- fifo_level is the registered level.

Optional Feature:
- Macro: AUDIO_FRAME_SCHEDULER_MIX_EN.
- Defined:
  - Both valid and not full: both readys are 1 and both frames are consumed together.
  - One entry is written holding the per-channel signed saturating sum, clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1] (for 16 bits, 32767 / -32768).
  - last_grant is unchanged by a mixed accept.
  - A single valid source behaves as in round robin.
- Undefined: round robin only; no adder logic is instantiated.

Test Plan:
- Reset, then src0 sends {L=0x1234,R=0x8001} with sinks ready -> src0_ready=1 next cycle; left_data=0x1234 and right_data=0x8001 valid one cycle after acceptance; popped same cycle; level returns to 0.
- src0 and src1 valid continuously, sinks stalled -> grants alternate src0, src1, src0, src1; level=4; both readys 0 while full.
- Left ready at cycle t, right ready at t+3 -> left_valid drops at t+1; right_valid held until t+3; pop at t+3; level decrements once.
- Empty FIFO, enable=1, left_ready=1 for 300 cycles -> underrun_count=255 (saturated); with enable=0, count frozen.
- Level=3 with left_done=1, pulse flush -> next cycle level=0, all valids 0; next push appears at the outputs with both done flags clear.
- MIX_EN build: src0 {0x7000,0x9000} and src1 {0x2000,0xF000} both valid -> single entry {0x7FFF,0x8000}; both readys 1 the same cycle.

Source files
------------

// File: rtl/audio_frame_scheduler.sv
// audio_frame_scheduler
//
// Shares the codec stereo playback path between two stereo frame requesters
// (src0 = sound effects, src1 = music/tone). Accepted frames are queued in a
// small frame FIFO. The head frame is offered to the codec's separate left
// and right Avalon-ST sinks. It is popped only once both channels have taken
// it.
//
// Optional feature: define AUDIO_FRAME_SCHEDULER_MIX_EN to mix simultaneous
// requests. Both frames are then consumed together and stored as one
// per-channel saturating sum. When the macro is undefined, the block
// arbitrates round robin only and no adders are built.
//
// Ports:
//   clk_clk              system clock, rising edge
//   reset_reset_n        synchronous active-low reset
//   enable               1 = run, 0 = stall both sides (state kept)
//   flush                one-cycle pulse that empties the FIFO
//   src0_* / src1_*      requester frame (left/right), valid, ready
//   left_* / right_*     codec channel sinks (data, valid, ready)
//   fifo_level           frames currently stored, 0..FIFO_DEPTH
//   underrun_count       saturating count of starved cycles
module audio_frame_scheduler #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset_n,
    input  logic                     enable,
    input  logic                     flush,
    input  logic signed [DATA_W-1:0] src0_left,
    input  logic signed [DATA_W-1:0] src0_right,
    input  logic                     src0_valid,
    output logic                     src0_ready,
    input  logic signed [DATA_W-1:0] src1_left,
    input  logic signed [DATA_W-1:0] src1_right,
    input  logic                     src1_valid,
    output logic                     src1_ready,
    output logic signed [DATA_W-1:0] left_data,
    output logic                     left_valid,
    input  logic                     left_ready,
    output logic signed [DATA_W-1:0] right_data,
    output logic                     right_valid,
    input  logic                     right_ready,
    output logic [ADDR_W:0]          fifo_level,
    output logic [7:0]               underrun_count
);

    logic [2*DATA_W-1:0]     mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]       wr_ptr;
    logic [ADDR_W-1:0]       rd_ptr;
    logic [ADDR_W:0]         level;
    logic [ADDR_W:0]         level_nxt;
    logic                    left_done;
    logic                    right_done;
    logic                    last_grant;   // index of the source that won last
    logic                    run;
    logic                    full;
    logic                    accept_ok;
    logic                    grant0;
    logic                    grant1;
    logic                    push;
    logic                    pop;
    logic                    left_hs;
    logic                    right_hs;
    logic signed [DATA_W-1:0] wr_left;
    logic signed [DATA_W-1:0] wr_right;
    logic [2*DATA_W-1:0]     head;

`ifdef AUDIO_FRAME_SCHEDULER_MIX_EN
    function automatic logic signed [DATA_W-1:0] sat_add(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [DATA_W:0] sum;
        sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        // The top two bits disagree only when the true sum left the DATA_W range.
        if (sum[DATA_W] != sum[DATA_W-1])
            sat_add = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                  : {1'b0, {(DATA_W-1){1'b1}}};
        else
            sat_add = sum[DATA_W-1:0];
    endfunction
`endif

    // Input arbitration and write-data selection
    always_comb begin
        run       = reset_reset_n & enable;
        full      = (level == (ADDR_W+1)'(FIFO_DEPTH));
        accept_ok = run & ~flush & ~full;
`ifdef AUDIO_FRAME_SCHEDULER_MIX_EN
        // Simultaneous requests are both taken and mixed into one entry.
        grant0 = src0_valid;
        grant1 = src1_valid;
`else
        // Round robin: on a contest, the source that did not win last time wins.
        grant0 = src0_valid & (~src1_valid | last_grant);
        grant1 = src1_valid & (~src0_valid | ~last_grant);
`endif
        src0_ready = accept_ok & grant0;
        src1_ready = accept_ok & grant1;
        push       = src0_ready | src1_ready;

        wr_left  = src1_left;
        wr_right = src1_right;
`ifdef AUDIO_FRAME_SCHEDULER_MIX_EN
        if (src0_ready & src1_ready) begin
            wr_left  = sat_add(src0_left, src1_left);
            wr_right = sat_add(src0_right, src1_right);
        end else if (src0_ready) begin
            wr_left  = src0_left;
            wr_right = src0_right;
        end
`else
        if (src0_ready) begin
            wr_left  = src0_left;
            wr_right = src0_right;
        end
`endif
    end

    // Output side: per-channel presentation of the head frame
    always_comb begin
        head        = mem[rd_ptr];
        left_valid  = run & (level != '0) & ~left_done;
        right_valid = run & (level != '0) & ~right_done;
        left_data   = left_valid  ? $signed(head[2*DATA_W-1:DATA_W]) : '0;
        right_data  = right_valid ? $signed(head[DATA_W-1:0])        : '0;
        left_hs     = left_valid  & left_ready;
        right_hs    = right_valid & right_ready;
        // Pop once each channel has either finished earlier or finishes now.
        pop         = (left_hs | right_hs) & (left_done | left_hs) & (right_done | right_hs);

        case ({push, pop})
            2'b10:   level_nxt = level + (ADDR_W+1)'(1);
            2'b01:   level_nxt = level - (ADDR_W+1)'(1);
            default: level_nxt = level;
        endcase
    end

    // Control state
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            left_done      <= 1'b0;
            right_done     <= 1'b0;
            last_grant     <= 1'b1;
            underrun_count <= 8'd0;
        end else if (enable) begin
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                level      <= '0;
                left_done  <= 1'b0;
                right_done <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                if (pop)
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                level <= level_nxt;

                if (pop) begin
                    left_done  <= 1'b0;
                    right_done <= 1'b0;
                end else begin
                    if (left_hs)
                        left_done <= 1'b1;
                    if (right_hs)
                        right_done <= 1'b1;
                end

                // A mixed accept (both readys) leaves the round-robin state alone.
                if (src0_ready & ~src1_ready)
                    last_grant <= 1'b0;
                else if (src1_ready & ~src0_ready)
                    last_grant <= 1'b1;

                if ((level == '0) && (left_ready | right_ready) && (underrun_count != 8'hFF))
                    underrun_count <= underrun_count + 8'd1;
            end
        end
    end

    // Frame storage (data only, no reset)
    always_ff @(posedge clk_clk) begin
        if (push)
            mem[wr_ptr] <= {wr_left, wr_right};
    end

    assign fifo_level = level;

endmodule
